// File: rtl/sram_fifo_ctrl.sv
// FIFO controller over an external 1W/1R SRAM with 1-cycle read latency; a skid
// register keeps out_data steady under backpressure. Define SRAM_FIFO_LEVEL_EN to expose level/almost_full.
module sram_fifo_ctrl #(
  parameter int unsigned RAM_DATA_WIDTH = 272,
  parameter int unsigned RAM_ADDR_WIDTH = 8,
  parameter int unsigned RAM_DEPTH      = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [RAM_DATA_WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [RAM_DATA_WIDTH-1:0] out_data,
  output logic                      sram_wr_en,
  output logic                      sram_port_en_1,
  output logic [RAM_ADDR_WIDTH-1:0] sram_addr_in_1,
  output logic [RAM_DATA_WIDTH-1:0] sram_data_in,
  output logic                      sram_rd_en,
  output logic                      sram_port_en_0,
  output logic [RAM_ADDR_WIDTH-1:0] sram_addr_in_0,
  input  logic [RAM_DATA_WIDTH-1:0] sram_data_out_0
`ifdef SRAM_FIFO_LEVEL_EN
  ,
  output logic [RAM_ADDR_WIDTH:0]   level,
  output logic                      almost_full
`endif
);

  localparam int unsigned CNT_W = RAM_ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAM_DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(RAM_DEPTH - 4);

  logic [RAM_ADDR_WIDTH-1:0] wr_ptr;
  logic [RAM_ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]          count;
  logic                      rd_pending;
  logic [RAM_DATA_WIDTH-1:0] hold_q;
  logic                      push;
  logic                      rd_issue;

  // Handshake decode; reset masks every strobe so the SRAM sees no enables.
  always_comb begin
    in_ready = 1'b0;
    push     = 1'b0;
    rd_issue = 1'b0;
    if (!rst) begin
      in_ready = (count != FULL_CNT);
      push     = in_valid && in_ready;
      // Reads only come from words already counted, so a same-cycle push never falls through.
      rd_issue = (count != '0) && (!out_valid || out_ready);
    end
  end

  assign sram_wr_en     = push;
  assign sram_port_en_1 = push;
  assign sram_addr_in_1 = wr_ptr;
  assign sram_data_in   = in_data;

  assign sram_rd_en     = rd_issue;
  assign sram_port_en_0 = rd_issue;
  assign sram_addr_in_0 = rd_ptr;

  // Fresh SRAM data goes straight out; a stalled word is replayed from hold_q.
  assign out_data = rd_pending ? sram_data_out_0 : hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_pending <= 1'b0;
      out_valid  <= 1'b0;
      hold_q     <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + RAM_ADDR_WIDTH'(1);
      if (rd_issue) rd_ptr <= rd_ptr + RAM_ADDR_WIDTH'(1);
      if (push && !rd_issue)      count <= count + CNT_W'(1);
      else if (!push && rd_issue) count <= count - CNT_W'(1);
      rd_pending <= rd_issue;
      out_valid  <= rd_issue || (out_valid && !out_ready);
      if (rd_pending) hold_q <= sram_data_out_0;
    end
  end

`ifdef SRAM_FIFO_LEVEL_EN
  assign level       = rst ? '0 : count;
  assign almost_full = !rst && (count >= AF_CNT);
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Randomized bench for sram_fifo_ctrl: behavioural SRAM plus a queue-based model
// of stored words and the presented output word, scored every cycle.
module tb_sram_fifo_ctrl;
  localparam int DW    = 272;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic          sram_wr_en, sram_port_en_1, sram_rd_en, sram_port_en_0;
  logic [AW-1:0] sram_addr_in_1, sram_addr_in_0;
  logic [DW-1:0] sram_data_in, sram_data_out_0;
`ifdef SRAM_FIFO_LEVEL_EN
  logic [AW:0]   level;
  logic          almost_full;
`endif

  always #5 clk = ~clk;

  sram_fifo_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sram_wr_en(sram_wr_en), .sram_port_en_1(sram_port_en_1),
    .sram_addr_in_1(sram_addr_in_1), .sram_data_in(sram_data_in),
    .sram_rd_en(sram_rd_en), .sram_port_en_0(sram_port_en_0),
    .sram_addr_in_0(sram_addr_in_0), .sram_data_out_0(sram_data_out_0)
`ifdef SRAM_FIFO_LEVEL_EN
    , .level(level), .almost_full(almost_full)
`endif
  );

  // Behavioural SRAM: registered read, one cycle latency.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (sram_wr_en && sram_port_en_1) mem[sram_addr_in_1] <= sram_data_in;
    if (sram_rd_en && sram_port_en_0) sram_data_out_0 <= mem[sram_addr_in_0];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Model: words sitting in SRAM, plus the one word presented on the output.
  logic [DW-1:0] store[$];
  logic          pv;
  logic [DW-1:0] pw;
  int            wr_cnt, rd_cnt;

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w = '0;
    for (int i = 0; i < DW; i += 32) w = {w[DW-33:0], 32'($urandom)};
    return w;
  endfunction

  // One clock: score DUT outputs at the falling edge, then advance the model.
  task automatic tick();
    logic push_e, issue_e, ir_e;
    @(negedge clk);
    ir_e    = !rst && (store.size() != DEPTH);
    push_e  = ir_e && in_valid;
    issue_e = !rst && (store.size() != 0) && (!pv || out_ready);
    n_checks++;
    if (in_ready !== ir_e) begin n_fail++; $display("FAIL in_ready: got %b exp %b t=%0t", in_ready, ir_e, $time); end
    n_checks++;
    if (out_valid !== pv) begin n_fail++; $display("FAIL out_valid: got %b exp %b t=%0t", out_valid, pv, $time); end
    if (pv) begin
      n_checks++;
      if (out_data !== pw) begin n_fail++; $display("FAIL out_data: got %h exp %h t=%0t", out_data, pw, $time); end
    end
    n_checks++;
    if (sram_wr_en !== push_e || sram_port_en_1 !== push_e) begin
      n_fail++; $display("FAIL wr_en: got %b/%b exp %b t=%0t", sram_wr_en, sram_port_en_1, push_e, $time);
    end
    if (push_e) begin
      n_checks++;
      if (sram_addr_in_1 !== AW'(wr_cnt) || sram_data_in !== in_data) begin
        n_fail++; $display("FAIL wr_addr: got %0d exp %0d t=%0t", sram_addr_in_1, AW'(wr_cnt), $time);
      end
    end
    n_checks++;
    if (sram_rd_en !== issue_e || sram_port_en_0 !== issue_e) begin
      n_fail++; $display("FAIL rd_en: got %b/%b exp %b t=%0t", sram_rd_en, sram_port_en_0, issue_e, $time);
    end
    if (issue_e) begin
      n_checks++;
      if (sram_addr_in_0 !== AW'(rd_cnt)) begin
        n_fail++; $display("FAIL rd_addr: got %0d exp %0d t=%0t", sram_addr_in_0, AW'(rd_cnt), $time);
      end
    end
`ifdef SRAM_FIFO_LEVEL_EN
    n_checks++;
    if (level !== (rst ? (AW+1)'(0) : (AW+1)'(store.size())) ||
        almost_full !== (!rst && store.size() >= DEPTH - 4)) begin
      n_fail++; $display("FAIL level: got %0d/%b exp %0d t=%0t", level, almost_full, store.size(), $time);
    end
`endif
    @(posedge clk);
    if (rst) begin
      store.delete(); pv = 1'b0; wr_cnt = 0; rd_cnt = 0;
    end else begin
      if (issue_e) begin pw = store.pop_front(); rd_cnt++; end
      pv = issue_e || (pv && !out_ready);
      if (push_e) begin store.push_back(in_data); wr_cnt++; end
    end
    #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((out_valid === 1'b1 || store.size() != 0) && n < 400) begin tick(); n++; end
    n_checks++;
    if (n >= 400) begin n_fail++; $display("FAIL drain_timeout: got %0d cycles exp <400", n); end
  endtask

  task automatic test_reset();
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || sram_wr_en !== 1'b0 || sram_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold: got ir=%b ov=%b we=%b re=%b exp 0", in_ready, out_valid, sram_wr_en, sram_rd_en);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: got ir=%b ov=%b exp 1/0", in_ready, out_valid);
    end
    repeat (2) tick();
  endtask

  task automatic test_latency();
    in_valid = 1'b1; in_data = DW'(1); out_ready = 1'b1;
    #1;
    n_checks++;
    if (sram_wr_en !== 1'b1 || sram_addr_in_1 !== AW'(0)) begin
      n_fail++; $display("FAIL lat_T: got we=%b a=%0d exp 1/0", sram_wr_en, sram_addr_in_1);
    end
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (sram_rd_en !== 1'b1 || sram_addr_in_0 !== AW'(0) || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL lat_T1: got re=%b a=%0d ov=%b exp 1/0/0", sram_rd_en, sram_addr_in_0, out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== DW'(1)) begin
      n_fail++; $display("FAIL lat_T2: got ov=%b d=%h exp 1/1", out_valid, out_data);
    end
    tick();
  endtask

  // SRAM holds DEPTH words; the output register holds one more.
  task automatic test_fill();
    int acc = 0;
    in_valid = 1'b1; out_ready = 1'b0;
    while (in_ready === 1'b1 && acc < 300) begin in_data = rand_word(); tick(); acc++; end
    n_checks++;
    if (acc != DEPTH + 1) begin n_fail++; $display("FAIL fill_count: got %0d exp %0d", acc, DEPTH + 1); end
    in_data = rand_word();
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL full_state: got ir=%b ov=%b exp 0/1", in_ready, out_valid);
    end
`ifdef SRAM_FIFO_LEVEL_EN
    n_checks++;
    if (level !== (AW+1)'(DEPTH) || almost_full !== 1'b1) begin
      n_fail++; $display("FAIL full_level: got %0d/%b exp %0d/1", level, almost_full, DEPTH);
    end
`endif
  endtask

  task automatic test_drain();
    int n = 0;
    out_ready = 1'b1;
    while (out_valid === 1'b1 && n < 300) begin tick(); n++; end
    n_checks++;
    if (n != DEPTH + 1) begin n_fail++; $display("FAIL drain_run: got %0d cycles exp %0d", n, DEPTH + 1); end
  endtask

  task automatic test_wrap();
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (4) begin in_data = rand_word(); tick(); end
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = rand_word();
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL wrap_stream: got ov=%b ir=%b exp 1/1 i=%0d", out_valid, in_ready, i);
      end
`ifdef SRAM_FIFO_LEVEL_EN
      n_checks++;
      if (level !== (AW+1)'(3)) begin n_fail++; $display("FAIL wrap_level: got %0d exp 3 i=%0d", level, i); end
`endif
      tick();
    end
    drain();
  endtask

  task automatic test_stall();
    int pops = 0;
    logic [DW-1:0] held;
    logic stalled;
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (8) begin in_data = rand_word(); tick(); end
    in_valid = 1'b0;
    stalled = 1'b0;
    for (int i = 0; i < 40; i++) begin
      out_ready = i[0];
      #1;
      if (stalled) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          n_fail++; $display("FAIL stall_hold: got ov=%b d=%h exp 1/%h", out_valid, out_data, held);
        end
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (out_valid && out_ready) pops++;
      tick();
    end
    n_checks++;
    if (pops != 8 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_pops: got %0d ov=%b exp 8/0", pops, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (5) begin in_data = rand_word(); tick(); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || sram_wr_en !== 1'b0 || sram_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL midrst_hold: got ov=%b ir=%b we=%b re=%b exp 0", out_valid, in_ready, sram_wr_en, sram_rd_en);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sram_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL midrst_release: got ir=%b ov=%b re=%b exp 1/0/0", in_ready, out_valid, sram_rd_en);
    end
    repeat (3) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = rand_word();
      tick();
    end
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    store.delete(); pv = 1'b0; pw = '0; wr_cnt = 0; rd_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_latency();
    test_fill();
    test_drain();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule
